// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack and its fetch/execute reader.
//   opcode_t      : ALU operation code (4-bit encoding; codes 8..15 are undefined)
//   operand_t     : signed 32-bit operand
//   address_t     : register-stack location (5 bits, 32 entries)
//   instruction_t : packed {opc, op_a, op_b} as stored in the stack
//   result_t      : signed 64-bit execution result
//   fe_state_t    : fetch/execute controller states
package instr_register_pkg;

  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, OUT, DONE
  } fe_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational executor for one instruction.
//   instr  : instruction to execute {opc, op_a, op_b}
//   result : signed 64-bit result (operands sign-extended first)
//   err    : divide/modulo by zero, or undefined opcode (result forced to 0)
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      result,
  output logic         err
);

  result_t a;
  result_t b;

  // Working at 64 bits keeps the full product and avoids the
  // most-negative / -1 overflow that 32-bit division would have.
  always_comb begin
    a      = result_t'(instr.op_a);
    b      = result_t'(instr.op_b);
    result = '0;
    err    = 1'b0;
    case (instr.opc)
      ZERO:  result = '0;
      PASSA: result = a;
      PASSB: result = b;
      ADD:   result = a + b;
      SUB:   result = a - b;
      MULT:  result = a * b;
      DIV: begin
        if (b == '0) err = 1'b1;
        else         result = a / b;
      end
      MOD: begin
        if (b == '0) err = 1'b1;
        else         result = a % b;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_exec.sv
// Reader/executor on the read side of the instruction register stack.
// Walks read_pointer over count locations from start_addr, executes each
// instruction and presents one result per instruction on a valid/ready port.
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   start             : run request, honoured only when idle
//   start_addr, count : first location and number of instructions (clamped)
//   read_pointer      : registered address into the register stack
//   instruction_word  : combinational read data at read_pointer
//   res_valid/ready   : result handshake
//   res_data/opc/addr/err : result, its opcode, source location, error flag
//   busy              : high whenever not idle
//   done              : one-cycle pulse at the end of a run
module instr_fetch_exec
  import instr_register_pkg::*;
#(
  parameter int unsigned NUM_REGS = instr_register_pkg::NUM_REGS,
  parameter int unsigned CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  address_t         start_addr,
  input  logic [CNT_W-1:0] count,
  output address_t         read_pointer,
  input  instruction_t     instruction_word,
  output logic             res_valid,
  input  logic             res_ready,
  output result_t          res_data,
  output opcode_t          res_opc,
  output address_t         res_addr,
  output logic             res_err,
  output logic             busy,
  output logic             done
);

  fe_state_t        state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count_clamped;
  instruction_t     instr_q;
  result_t          alu_result;
  logic             alu_err;

  assign count_clamped = (count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : count;
  assign busy          = (state != IDLE);

  instr_alu u_alu (
    .instr  (instr_q),
    .result (alu_result),
    .err    (alu_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      read_pointer <= '0;
      remaining    <= '0;
      instr_q      <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_opc      <= ZERO;
      res_addr     <= '0;
      res_err      <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            read_pointer <= start_addr;
            remaining    <= count_clamped;
            state        <= (count_clamped == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          instr_q <= instruction_word;
          state   <= EXEC;
        end
        EXEC: begin
          res_data  <= alu_result;
          res_opc   <= instr_q.opc;
          res_err   <= alu_err;
          res_addr  <= read_pointer;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end else begin
              read_pointer <= (read_pointer == address_t'(NUM_REGS - 1))
                              ? '0 : read_pointer + 1'b1;
              state        <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_exec.md
Name: instr_fetch_exec

Overview:
Reader/executor on the read side of the instruction register stack. On a start command it walks read_pointer over a contiguous block of register locations and captures each instruction_word. It executes the opcode on the two operands and presents one result per instruction on a valid/ready output port. It replaces the bench's manual read-back loop and is the consumer end of the load_en/write_pointer write protocol.

Parameters:
NUM_REGS, 32, depth of the instruction register stack; read_pointer wraps modulo NUM_REGS.
CNT_W, 6, width of count; must hold NUM_REGS.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  run request, sampled in IDLE only
start_addr  input  address_t (5)  first location to read
count  input  CNT_W  number of instructions; 0 = none; values >NUM_REGS clamp to NUM_REGS
read_pointer  output  address_t (5)  registered address to the instruction register
instruction_word  input  instruction_t  {opc, op_a, op_b}; combinational read of read_pointer
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  result_t (64, signed)  execution result
res_opc  output  opcode_t  opcode of the result
res_addr  output  address_t  location the instruction came from
res_err  output  1  divide/modulo by zero
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset (asynchronous, any state): state=IDLE. read_pointer=0, res_valid=0, res_data=0, res_opc=ZERO, res_addr=0, res_err=0, busy=0, done=0, remaining=0.
- States: IDLE, FETCH, EXEC, OUT, DONE.
- IDLE: on start=1 at an edge, latch start_addr into read_pointer and clamp(count) into remaining. count=0 goes to DONE; otherwise go to FETCH.
- FETCH: read_pointer is stable this cycle. At the edge, capture instruction_word into an internal register, then go to EXEC.
- EXEC: compute from the captured instruction. At the edge, register res_data, res_opc, res_err and res_addr=read_pointer, set res_valid=1, then go to OUT.
- OUT: hold all res_* stable while res_valid=1 and res_ready=0, with no limit on stall length. On an edge with res_ready=1:
  - clear res_valid and decrement remaining.
  - if remaining was 1, go to DONE.
  - otherwise read_pointer = (read_pointer+1) mod NUM_REGS (31 wraps to 0) and go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start edge T gives res_valid at T+3. Steady state is 3 cycles per instruction with res_ready tied high.
- start while busy=1 is ignored; there is no queuing.
- Arithmetic (result_t is signed 64-bit, operands sign-extended):
  - ZERO gives 0.
  - PASSA gives op_a; PASSB gives op_b.
  - ADD gives op_a+op_b; SUB gives op_a-op_b.
  - MULT gives the full 64-bit signed product.
  - DIV truncates toward zero.
  - MOD result takes the sign of op_a.
  - DIV/MOD with op_b=0: res_data=0, res_err=1.
  - All other cases: res_err=0.
- Opcode values outside the enum give res_data=0 and res_err=1.
- instruction_word is only sampled in FETCH; changes in other states have no effect.

Decomposition:
- Add to instr_register_pkg:
  - result_t (signed 64-bit)
  - fe_state_t enum {IDLE, FETCH, EXEC, OUT, DONE}
  - NUM_REGS constant
- instr_fetch_exec reuses the existing opcode_t, operand_t, address_t and instruction_t.
- One combinational sub-module, instr_alu: inputs instruction_t; outputs result_t and err. It holds all arithmetic and divide-by-zero handling, so it can be unit-checked standalone.

Test Plan:
1. Preload loc0={ADD,5,3}, loc1={SUB,-7,2}, loc2={MULT,-4,6}; start_addr=0, count=3, res_ready=1 -> results 8, -9, -24 with res_addr 0, 1, 2; first res_valid at start+3 cycles; done pulse after third handshake.
2. loc5={DIV,7,0}, loc6={MOD,-7,3}; start_addr=5, count=2 -> first result res_data=0 with res_err=1; second result res_data=-1 with res_err=0.
3. Wrap-around: start_addr=31, count=2, loc31={PASSA,-15,0}, loc0={PASSB,0,9} -> res_addr 31 then 0; res_data -15 then 9.
4. Backpressure: res_ready=0 for 10 cycles after the first res_valid -> res_data, res_addr and res_valid held constant; read_pointer unchanged; next FETCH only after the accepting edge.
5. count=0 -> no res_valid; done pulses 2 cycles after start. A second start during busy is ignored: result count equals the first count.
6. Assert reset mid-OUT with res_valid=1 -> all outputs return to reset values asynchronously, without waiting for clk. A new start after deassertion runs normally from its own start_addr.
